// File: rtl/level_controller_if.sv
// level_controller_if: link between the level controller and the safe-zone map.
// master = controller side, slave = map side.
interface level_controller_if #(
    parameter int SCREEN_WIDTH  = 400,
    parameter int SCREEN_HEIGHT = 600
);
    logic                             o_regenerate_level;
    logic                             i_zone_rdy;
    logic [$clog2(SCREEN_WIDTH)-1:0]  o_query_x;
    logic [$clog2(SCREEN_HEIGHT)-1:0] o_query_y;
    logic                             i_is_safe;
    modport master (output o_regenerate_level, o_query_x, o_query_y, input i_zone_rdy, i_is_safe);
    modport slave  (input o_regenerate_level, o_query_x, o_query_y, output i_zone_rdy, i_is_safe);
endinterface

// File: rtl/level_controller.sv
// level_controller: per-frame safe-zone checking, lives, grace and level progression.
// Score counter is built only when LEVEL_CTRL_SCORE_EN is defined.
module level_controller #(
    parameter int SCREEN_WIDTH  = 400,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BLOCK_SIZE    = 20,
    parameter int LIVES         = 3,
    parameter int GRACE_FRAMES  = 30
) (
    input  logic                             clk,
    input  logic                             arst_n,
    input  logic                             i_start,
    input  logic                             i_frame_tick,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]  i_player_x,
    input  logic [$clog2(SCREEN_HEIGHT)-1:0] i_player_y,
    level_controller_if.master               m_if,
    output logic [2:0]                       o_state,
    output logic [2:0]                       o_lives,
    output logic [7:0]                       o_level,
    output logic                             o_hit,
    output logic                             o_game_over,
    output logic [15:0]                      o_score
);
    localparam int XW = $clog2(SCREEN_WIDTH);
    localparam int YW = $clog2(SCREEN_HEIGHT);
    localparam logic [XW-1:0] X_MAX = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_HEIGHT - 1);
    localparam logic [YW-1:0] Y_TOP = YW'(SCREEN_HEIGHT - BLOCK_SIZE);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_REGEN_REQ  = 3'd1;
    localparam logic [2:0] S_REGEN_WAIT = 3'd2;
    localparam logic [2:0] S_PLAY       = 3'd3;
    localparam logic [2:0] S_CHECK      = 3'd4;
    localparam logic [2:0] S_LEVEL_UP   = 3'd5;
    localparam logic [2:0] S_GAME_OVER  = 3'd6;

    logic [2:0]    r_state;
    logic [2:0]    r_lives;
    logic [7:0]    r_level;
    logic [7:0]    r_grace;
    logic          r_wait2;
    logic          r_armed;
    logic [XW-1:0] r_qx;
    logic [YW-1:0] r_qy;
    logic          w_check;
    logic          w_top;
    logic          w_hit;

    assign w_check = r_state == S_CHECK;
    assign w_top   = r_qy >= Y_TOP;
    // r_armed holds "grace was already zero when this frame was accepted"
    assign w_hit   = w_check && !w_top && !m_if.i_is_safe && r_armed && r_lives != 3'd0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
            r_lives <= '0;
            r_level <= '0;
            r_grace <= '0;
            r_wait2 <= 1'b0;
            r_armed <= 1'b0;
            r_qx    <= '0;
            r_qy    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_GAME_OVER: if (i_start) begin
                    r_state <= S_REGEN_REQ;
                    r_lives <= 3'(LIVES);
                    r_level <= '0;
                    r_grace <= '0;
                end
                S_REGEN_REQ: begin
                    r_state <= S_REGEN_WAIT;
                    r_wait2 <= 1'b0;
                end
                S_REGEN_WAIT: begin
                    r_wait2 <= 1'b1;
                    if (r_wait2 && m_if.i_zone_rdy) r_state <= S_PLAY;
                end
                S_PLAY: if (i_frame_tick) begin
                    r_state <= S_CHECK;
                    r_qx    <= (i_player_x > X_MAX) ? X_MAX : i_player_x;
                    r_qy    <= (i_player_y > Y_MAX) ? Y_MAX : i_player_y;
                    r_armed <= r_grace == 8'd0;
                    r_grace <= (r_grace != 8'd0) ? r_grace - 8'd1 : r_grace;
                end
                S_CHECK: begin
                    r_state <= w_top ? S_LEVEL_UP : (w_hit && r_lives == 3'd1) ? S_GAME_OVER : S_PLAY;
                    if (w_hit) begin
                        r_lives <= r_lives - 3'd1;
                        r_grace <= 8'(GRACE_FRAMES);
                    end
                end
                S_LEVEL_UP: begin
                    r_state <= S_REGEN_REQ;
                    r_level <= (r_level == 8'hFF) ? r_level : r_level + 8'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LEVEL_CTRL_SCORE_EN
    logic [15:0] r_score;
    logic [16:0] w_score_sum;
    assign w_score_sum = {1'b0, r_score} + ((r_state == S_LEVEL_UP) ? 17'd100 : 17'd1);
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            r_score <= '0;
        else if (i_start && (r_state == S_IDLE || r_state == S_GAME_OVER))
            r_score <= '0;
        else if ((w_check && !w_top && !w_hit) || r_state == S_LEVEL_UP)
            r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    end
    assign o_score = r_score;
`else
    assign o_score = '0;
`endif

    assign m_if.o_regenerate_level = r_state == S_REGEN_REQ;
    assign m_if.o_query_x          = r_qx;
    assign m_if.o_query_y          = r_qy;
    assign o_state                 = r_state;
    assign o_lives                 = r_lives;
    assign o_level                 = r_level;
    assign o_hit                   = w_hit;
    assign o_game_over             = r_state == S_GAME_OVER;
endmodule
